// File: rtl/pic_pkg.sv
// pic_pkg: definitions shared by the interrupt priority unit and its control logic.
//   - OCW2 command encodings, ordered {R, SL, EOI}
//   - priority-resolution FSM state type
//   - SPURIOUS_LEVEL: the vector level reported when no request survives to first_ACK
//   - prio_rank(): converts a level into its rank under the current rotation (0 = highest)
package pic_pkg;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_S_EOI        = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } pic_state_e;

  // Level (lowest_prio+1) mod 8 ranks 0; ranks increase wrapping upward.
  function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                           input logic [2:0] lowest_prio);
    return level - lowest_prio - 3'd1;
  endfunction

endpackage

// File: rtl/interrupt_priority_unit_if.sv
// interrupt_priority_unit_if: groups the request, mask, acknowledge, OCW2 and
// readback signals of the interrupt priority unit.
//   master : the surrounding PIC logic / environment (drives requests, ACKs, OCW2)
//   slave  : the interrupt priority unit itself (drives INT, INT_VEC, IRR, ISR)
interface interrupt_priority_unit_if;

  logic [7:0] IR;
  logic       LTIM;
  logic [7:0] IM;
  logic       AEOI;
  logic       first_ACK;
  logic       second_ACK;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;
  logic       INT;
  logic [2:0] INT_VEC;
  logic [7:0] IRR;
  logic [7:0] ISR;

  modport master (
    output IR, LTIM, IM, AEOI, first_ACK, second_ACK,
           ocw2_valid, ocw2_cmd, ocw2_level,
    input  INT, INT_VEC, IRR, ISR
  );

  modport slave (
    input  IR, LTIM, IM, AEOI, first_ACK, second_ACK,
           ocw2_valid, ocw2_cmd, ocw2_level,
    output INT, INT_VEC, IRR, ISR
  );

endinterface

// File: rtl/pic_prio_encoder.sv
// pic_prio_encoder: combinational rotating find-first over 8 request bits.
//   req         in  8  request bits
//   lowest_prio in  3  lowest-priority level; search starts at lowest_prio+1
//   valid       out 1  at least one bit of req is set
//   level       out 3  highest-priority set bit (0 when valid=0)
module pic_prio_encoder (
  input  logic [7:0] req,
  input  logic [2:0] lowest_prio,
  output logic       valid,
  output logic [2:0] level
);

  logic [2:0] idx;

  always_comb begin
    valid = 1'b0;
    level = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = lowest_prio + 3'd1 + 3'(i);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_priority_unit.sv
// interrupt_priority_unit: latches IR0..IR7 into the IRR, applies the IM mask,
// resolves priority against the ISR (fully nested, optionally rotating) and
// raises INT towards the CPU. Tracks the two-pulse INTA handshake and applies
// OCW2 EOI / rotation commands.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : interrupt_priority_unit_if.slave
//                IR/LTIM/IM/AEOI, first_ACK/second_ACK, ocw2_valid/cmd/level in;
//                INT, INT_VEC, IRR, ISR out (all registered)
// Build option: define ROTATION_EN for programmable lowest priority, rotating
// EOI commands and rotate-on-AEOI. Without it priority is fixed (IR0 highest).
module interrupt_priority_unit
  import pic_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  interrupt_priority_unit_if.slave bus
);

  logic [7:0] ir_q;
  logic [7:0] irr_q;
  logic [7:0] isr_q;
  logic [2:0] vec_q;
  logic       int_q;
  logic       spur_q;
  pic_state_e state;

  logic [2:0] lowest_prio;

`ifdef ROTATION_EN
  logic [2:0] lowest_q;
  logic       rot_aeoi_q;
  logic       prio_load;
  logic [2:0] prio_val;
  logic       rot_set;
  logic       rot_clr;

  assign lowest_prio = lowest_q;
`else
  assign lowest_prio = 3'd7;
`endif

  // Priority resolution
  logic [7:0] req_masked;
  logic       irr_valid;
  logic [2:0] irr_level;
  logic       isr_valid;
  logic [2:0] isr_level;
  logic       cand_valid;

  assign req_masked = irr_q & ~bus.IM;

  pic_prio_encoder u_irr_enc (
    .req         (req_masked),
    .lowest_prio (lowest_prio),
    .valid       (irr_valid),
    .level       (irr_level)
  );

  pic_prio_encoder u_isr_enc (
    .req         (isr_q),
    .lowest_prio (lowest_prio),
    .valid       (isr_valid),
    .level       (isr_level)
  );

  // Only the top pending request needs to beat the top in-service level;
  // masked ISR bits are not filtered, so they keep blocking lower levels.
  assign cand_valid = irr_valid &&
                      (!isr_valid ||
                       (prio_rank(irr_level, lowest_prio) <
                        prio_rank(isr_level, lowest_prio)));

  // Handshake, EOI and IRR next-state terms
  logic       ack_take;
  logic       ack2_take;
  logic [7:0] ack_set;
  logic [7:0] eoi_clr;
  logic [7:0] irr_next;

  assign ack_take  = (state == IDLE)  && bus.first_ACK;
  assign ack2_take = (state == WAIT2) && bus.second_ACK;

  always_comb begin
    ack_set = '0;
    if (ack_take && cand_valid)
      ack_set = 8'(1) << irr_level;
  end

  always_comb begin
    if (bus.LTIM) begin
      irr_next = bus.IR;
    end else begin
      // Set on a rising edge, dropped as soon as the line falls.
      irr_next = (irr_q | (bus.IR & ~ir_q)) & bus.IR;
    end
    irr_next = irr_next & ~ack_set;
  end

  always_comb begin
    eoi_clr = '0;
`ifdef ROTATION_EN
    prio_load = 1'b0;
    prio_val  = lowest_q;
    rot_set   = 1'b0;
    rot_clr   = 1'b0;
    if (ack2_take && bus.AEOI && rot_aeoi_q) begin
      prio_load = 1'b1;
      prio_val  = vec_q;
    end
`endif
    if (ack2_take && bus.AEOI && !spur_q)
      eoi_clr[vec_q] = 1'b1;

    // OCW2 is evaluated after the AEOI terms so a same-cycle priority write
    // from software takes precedence over rotate-on-AEOI.
    if (bus.ocw2_valid) begin
      case (bus.ocw2_cmd)
        OCW2_NS_EOI: begin
          if (isr_valid) eoi_clr[isr_level] = 1'b1;
        end
        OCW2_S_EOI: begin
          eoi_clr[bus.ocw2_level] = 1'b1;
        end
`ifdef ROTATION_EN
        OCW2_ROT_NS_EOI: begin
          if (isr_valid) begin
            eoi_clr[isr_level] = 1'b1;
            prio_load          = 1'b1;
            prio_val           = isr_level;
          end
        end
        OCW2_ROT_S_EOI: begin
          eoi_clr[bus.ocw2_level] = 1'b1;
          prio_load               = 1'b1;
          prio_val                = bus.ocw2_level;
        end
        OCW2_SET_PRIO: begin
          prio_load = 1'b1;
          prio_val  = bus.ocw2_level;
        end
        OCW2_ROT_AEOI_SET: rot_set = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_clr = 1'b1;
`else
        OCW2_ROT_NS_EOI: begin
          if (isr_valid) eoi_clr[isr_level] = 1'b1;
        end
        OCW2_ROT_S_EOI: begin
          eoi_clr[bus.ocw2_level] = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // State, readback registers and INTA handshake FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= '0;
      irr_q  <= '0;
      isr_q  <= '0;
      vec_q  <= SPURIOUS_LEVEL;
      int_q  <= 1'b0;
      spur_q <= 1'b0;
      state  <= IDLE;
    end else begin
      ir_q  <= bus.IR;
      irr_q <= irr_next;
      isr_q <= (isr_q & ~eoi_clr) | ack_set;
      // Held low through WAIT2 and on the acknowledging edge itself.
      int_q <= (state == IDLE) && !bus.first_ACK && cand_valid;

      case (state)
        IDLE: begin
          if (bus.first_ACK) begin
            vec_q  <= cand_valid ? irr_level : SPURIOUS_LEVEL;
            spur_q <= !cand_valid;
            state  <= WAIT2;
          end
        end
        WAIT2: begin
          if (bus.second_ACK)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROTATION_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lowest_q   <= 3'd7;
      rot_aeoi_q <= 1'b0;
    end else begin
      if (prio_load) lowest_q <= prio_val;
      if (rot_set)
        rot_aeoi_q <= 1'b1;
      else if (rot_clr)
        rot_aeoi_q <= 1'b0;
    end
  end
`endif

  assign bus.INT     = int_q;
  assign bus.INT_VEC = vec_q;
  assign bus.IRR     = irr_q;
  assign bus.ISR     = isr_q;

endmodule

// File: tb/tb_interrupt_priority_unit.sv
// tb_interrupt_priority_unit: table-driven directed bench for the interrupt
// priority unit. Each record holds one cycle of inputs and the outputs expected
// after the following rising edge. Reset mid-handshake and the priority
// rotation sequence are written out by hand.
module tb_interrupt_priority_unit;

  logic clk;
  logic rst_n;

  interrupt_priority_unit_if bus();

  interrupt_priority_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ir;
    logic [7:0] im;
    logic       ltim;
    logic       aeoi;
    logic       fa;
    logic       sa;
    logic       ov;
    logic [2:0] cmd;
    logic [2:0] lvl;
    logic       e_int;
    logic [2:0] e_vec;
    logic [7:0] e_irr;
    logic [7:0] e_isr;
  } vec_t;

  int tests;
  int failed;

  function automatic vec_t mk(input logic [7:0] ir, input logic [7:0] im,
                              input logic ltim, input logic aeoi,
                              input logic fa, input logic sa, input logic ov,
                              input logic [2:0] cmd, input logic [2:0] lvl,
                              input logic e_int, input logic [2:0] e_vec,
                              input logic [7:0] e_irr, input logic [7:0] e_isr);
    vec_t v;
    v.ir = ir; v.im = im; v.ltim = ltim; v.aeoi = aeoi;
    v.fa = fa; v.sa = sa; v.ov = ov; v.cmd = cmd; v.lvl = lvl;
    v.e_int = e_int; v.e_vec = e_vec; v.e_irr = e_irr; v.e_isr = e_isr;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_int,
                               input logic [2:0] e_vec, input logic [7:0] e_irr,
                               input logic [7:0] e_isr);
    check({tag, " INT"},     {7'd0, bus.INT},     {7'd0, e_int});
    check({tag, " INT_VEC"}, {5'd0, bus.INT_VEC}, {5'd0, e_vec});
    check({tag, " IRR"},     bus.IRR,             e_irr);
    check({tag, " ISR"},     bus.ISR,             e_isr);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus.IR         = v.ir;
    bus.IM         = v.im;
    bus.LTIM       = v.ltim;
    bus.AEOI       = v.aeoi;
    bus.first_ACK  = v.fa;
    bus.second_ACK = v.sa;
    bus.ocw2_valid = v.ov;
    bus.ocw2_cmd   = v.cmd;
    bus.ocw2_level = v.lvl;
    @(posedge clk);
    #1;
    check_outputs(tag, v.e_int, v.e_vec, v.e_irr, v.e_isr);
  endtask

  vec_t tbl[$];
  vec_t rot[$];

  localparam logic [2:0] R_VEC = `ifdef ROTATION_EN 3'd7 `else 3'd0 `endif ;
  localparam logic [7:0] R_IRR = `ifdef ROTATION_EN 8'h01 `else 8'h80 `endif ;
  localparam logic [7:0] R_ISR = `ifdef ROTATION_EN 8'h80 `else 8'h01 `endif ;

  initial begin
    tests  = 0;
    failed = 0;

    //             ir     im    lt a  fa sa ov cmd   lvl   INT VEC   IRR    ISR
    // Edge mode, fully nested, explicit EOIs
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd7, 8'h11, 8'h00));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd7, 8'h11, 8'h00));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 8'h10, 8'h01));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 8'h10, 8'h01));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 8'h10, 8'h01));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 0, 0, 1, 3'd1, 3'd0, 0, 3'd0, 8'h10, 8'h00));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd0, 8'h10, 8'h00));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd4, 8'h00, 8'h10));
    tbl.push_back(mk(8'h11, 8'h00, 0, 0, 0, 1, 0, 3'd0, 3'd0, 0, 3'd4, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 3'd3, 3'd4, 0, 3'd4, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd4, 8'h00, 8'h00));
    // AEOI with IR0 masked
    tbl.push_back(mk(8'h03, 8'h01, 0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd4, 8'h03, 8'h00));
    tbl.push_back(mk(8'h03, 8'h01, 0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 3'd4, 8'h03, 8'h00));
    tbl.push_back(mk(8'h03, 8'h01, 0, 1, 1, 0, 0, 3'd0, 3'd0, 0, 3'd1, 8'h01, 8'h02));
    tbl.push_back(mk(8'h03, 8'h01, 0, 1, 0, 1, 0, 3'd0, 3'd0, 0, 3'd1, 8'h01, 8'h00));
    tbl.push_back(mk(8'h03, 8'h01, 0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd1, 8'h01, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 3'd1, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd1, 8'h00, 8'h00));
    // Spurious: request withdrawn before first_ACK
    tbl.push_back(mk(8'h20, 8'h00, 0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd1, 8'h20, 8'h00));
    tbl.push_back(mk(8'h20, 8'h00, 0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 3'd1, 8'h20, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 3'd1, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 1, 0, 0, 3'd0, 3'd0, 0, 3'd7, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd0, 3'd0, 0, 3'd7, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd7, 8'h00, 8'h00));
    // Level-triggered
    tbl.push_back(mk(8'h08, 8'h00, 1, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd7, 8'h08, 8'h00));
    tbl.push_back(mk(8'h08, 8'h00, 1, 1, 0, 0, 0, 3'd0, 3'd0, 1, 3'd7, 8'h08, 8'h00));
    tbl.push_back(mk(8'h08, 8'h00, 1, 1, 1, 0, 0, 3'd0, 3'd0, 0, 3'd3, 8'h00, 8'h08));
    tbl.push_back(mk(8'h08, 8'h00, 1, 1, 0, 1, 0, 3'd0, 3'd0, 0, 3'd3, 8'h08, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 0, 0, 0, 3'd0, 3'd0, 1, 3'd3, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd3, 8'h00, 8'h00));
    // Nesting, then specific EOI coinciding with first_ACK
    tbl.push_back(mk(8'h04, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd3, 8'h04, 8'h00));
    tbl.push_back(mk(8'h04, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd3, 8'h04, 8'h00));
    tbl.push_back(mk(8'h04, 8'h00, 0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd2, 8'h00, 8'h04));
    tbl.push_back(mk(8'h04, 8'h00, 0, 0, 0, 1, 0, 3'd0, 3'd0, 0, 3'd2, 8'h00, 8'h04));
    tbl.push_back(mk(8'h06, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd2, 8'h02, 8'h04));
    tbl.push_back(mk(8'h06, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd2, 8'h02, 8'h04));
    tbl.push_back(mk(8'h06, 8'h00, 0, 0, 1, 0, 1, 3'd3, 3'd2, 0, 3'd1, 8'h00, 8'h02));

    // Priority rotation via OCW2 101 (plain non-specific EOI without ROTATION_EN)
    rot.push_back(mk(8'h01, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd7, 8'h01, 8'h00));
    rot.push_back(mk(8'h01, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd7, 8'h01, 8'h00));
    rot.push_back(mk(8'h01, 8'h00, 0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 8'h00, 8'h01));
    rot.push_back(mk(8'h01, 8'h00, 0, 0, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 8'h00, 8'h01));
    rot.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 3'd5, 3'd0, 0, 3'd0, 8'h00, 8'h00));
    rot.push_back(mk(8'h81, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 8'h81, 8'h00));
    rot.push_back(mk(8'h81, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd0, 8'h81, 8'h00));
    rot.push_back(mk(8'h81, 8'h00, 0, 0, 1, 0, 0, 3'd0, 3'd0, 0, R_VEC, R_IRR, R_ISR));
    rot.push_back(mk(8'h81, 8'h00, 0, 0, 0, 1, 0, 3'd0, 3'd0, 0, R_VEC, R_IRR, R_ISR));

    // Reset state
    rst_n          = 1'b0;
    bus.IR         = '0;
    bus.IM         = '0;
    bus.LTIM       = 1'b0;
    bus.AEOI       = 1'b0;
    bus.first_ACK  = 1'b0;
    bus.second_ACK = 1'b0;
    bus.ocw2_valid = 1'b0;
    bus.ocw2_cmd   = '0;
    bus.ocw2_level = '0;
    #22;
    check_outputs("reset", 1'b0, 3'd7, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // DUT is now in WAIT2 with ISR=02; reset must clear everything at once.
    @(negedge clk);
    bus.first_ACK  = 1'b0;
    bus.ocw2_valid = 1'b0;
    bus.ocw2_cmd   = '0;
    bus.ocw2_level = '0;
    #1;
    check_outputs("pre_reset", 1'b0, 3'd1, 8'h00, 8'h02);
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 3'd7, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check_outputs("held_reset", 1'b0, 3'd7, 8'h00, 8'h00);
    @(negedge clk);
    bus.IR = '0;
    rst_n  = 1'b1;

    for (int i = 0; i < rot.size(); i++)
      apply(rot[i], $sformatf("rot%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
